// File: rtl/param_updown_counter_if.sv
// Control/status bundle for param_updown_counter: master drives controls, slave returns count and flags.
interface param_updown_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             at_term;
  logic             ovf;

  modport master (
    output en, up, clr, load, load_val,
    input  count, at_term, ovf
  );

  modport slave (
    input  en, up, clr, load, load_val,
    output count, at_term, ovf
  );
endinterface

// File: rtl/param_updown_counter.sv
// Up/down counter over 0..MAX_VAL with wrap or saturate, clamped load, terminal-count and overflow flags.
// Optional CNTR_PRESCALE_EN: advance cycles only step the count once every PRESCALE of them.
module param_updown_counter #(
  parameter int               WIDTH    = 4,
  parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
  parameter bit               SAT_MODE = 1'b0,
  parameter int               PRESCALE = 4
) (
  input logic                   clk,
  input logic                   rst,
  param_updown_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             advance;
  logic             tick;
  logic             at_max, at_zero;
  logic [WIDTH-1:0] load_clamped;

  assign advance      = bus.en & ~bus.clr & ~bus.load;
  assign at_max       = (cnt_q == MAX_VAL);
  assign at_zero      = (cnt_q == ZERO);
  assign load_clamped = (bus.load_val > MAX_VAL) ? MAX_VAL : bus.load_val;

`ifdef CNTR_PRESCALE_EN
  localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q;

  assign tick = (pre_q == PRE_LAST);

  // Phase is kept across en=0 so a paused counter does not step early on resume.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    pre_q <= '0;
    else if (bus.clr | bus.load) pre_q <= '0;
    else if (bus.en)            pre_q <= tick ? '0 : pre_q + PW'(1);
  end
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = 1'b0;
    if (bus.clr) begin
      cnt_d = ZERO;
    end else if (bus.load) begin
      cnt_d = load_clamped;
    end else if (advance && tick) begin
      if (bus.up) begin
        if (at_max) begin
          ovf_d = 1'b1;
          cnt_d = SAT_MODE ? cnt_q : ZERO;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end else begin
        if (at_zero) begin
          ovf_d = 1'b1;
          cnt_d = SAT_MODE ? cnt_q : MAX_VAL;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.count   = cnt_q;
  assign bus.ovf     = ovf_q;
  assign bus.at_term = bus.up ? at_max : at_zero;

endmodule

// File: tb/tb_param_updown_counter.sv
// Scoreboard bench: wrap and saturate instances (MAX_VAL=9) share random + directed stimulus vs an arithmetic model.
module tb_param_updown_counter;
  localparam int MAXV = 9;
  localparam int PRE  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  param_updown_counter_if #(.WIDTH(4)) bw ();
  param_updown_counter_if #(.WIDTH(4)) bs ();

  param_updown_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SAT_MODE(1'b0), .PRESCALE(PRE))
    dut_wrap (.clk(clk), .rst(rst), .bus(bw));
  param_updown_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SAT_MODE(1'b1), .PRESCALE(PRE))
    dut_sat  (.clk(clk), .rst(rst), .bus(bs));

  typedef struct {
    int c[2];
    bit o[2];
    bit t[2];
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  int   mc[2];
  bit   mo[2];
  int   mp;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: spec rules as plain integer arithmetic.
  task automatic model(input bit e, input bit u, input bit c, input bit l, input int lv);
    bit step;
    step = 1'b0;
    if (!c && !l && e) begin
`ifdef CNTR_PRESCALE_EN
      step = (mp == PRE - 1);
      mp   = step ? 0 : mp + 1;
`else
      step = 1'b1;
`endif
    end
    if (c || l) mp = 0;
    for (int k = 0; k < 2; k++) begin
      mo[k] = 1'b0;
      if (c)         mc[k] = 0;
      else if (l)    mc[k] = (lv > MAXV) ? MAXV : lv;
      else if (step) begin
        if (u) begin
          if (mc[k] == MAXV) begin mo[k] = 1'b1; mc[k] = (k == 1) ? MAXV : 0; end
          else mc[k] = mc[k] + 1;
        end else begin
          if (mc[k] == 0) begin mo[k] = 1'b1; mc[k] = (k == 1) ? 0 : MAXV; end
          else mc[k] = mc[k] - 1;
        end
      end
    end
  endtask

  task automatic drive(input bit e, input bit u, input bit c, input bit l, input int lv);
    exp_t x;
    @(negedge clk);
    bw.en = e; bw.up = u; bw.clr = c; bw.load = l; bw.load_val = 4'(lv);
    bs.en = e; bs.up = u; bs.clr = c; bs.load = l; bs.load_val = 4'(lv);
    model(e, u, c, l, lv);
    for (int k = 0; k < 2; k++) begin
      x.c[k] = mc[k];
      x.o[k] = mo[k];
      x.t[k] = u ? (mc[k] == MAXV) : (mc[k] == 0);
    end
    sbq.push_back(x);
    @(posedge clk);
  endtask

  // Monitor: every edge with pending expectation is compared just after it.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("wrap_count", int'(bw.count), e.c[0]);
      chk("wrap_ovf",   int'(bw.ovf),   int'(e.o[0]));
      chk("wrap_term",  int'(bw.at_term), int'(e.t[0]));
      chk("sat_count",  int'(bs.count), e.c[1]);
      chk("sat_ovf",    int'(bs.ovf),   int'(e.o[1]));
      chk("sat_term",   int'(bs.at_term), int'(e.t[1]));
    end
  end

  task automatic set_idle();
    bw.en = 0; bw.up = 1; bw.clr = 0; bw.load = 0; bw.load_val = '0;
    bs.en = 0; bs.up = 1; bs.clr = 0; bs.load = 0; bs.load_val = '0;
  endtask

  initial begin
    set_idle();
    mc = '{0, 0}; mo = '{0, 0}; mp = 0;
    #1;
    chk("reset_count_w", int'(bw.count), 0);
    chk("reset_ovf_s",   int'(bs.ovf), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Async reset mid-count: reach 5, then assert rst between edges.
    drive(0, 1, 1, 0, 0);
    repeat (5) drive(1, 1, 0, 0, 0);
    @(negedge clk);
    set_idle();
    #2 rst = 1'b1;
    mc = '{0, 0}; mo = '{0, 0}; mp = 0;
    #1;
    chk("async_rst_count_w", int'(bw.count), 0);
    chk("async_rst_count_s", int'(bs.count), 0);
    chk("async_rst_ovf_w",   int'(bw.ovf), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) drive(1, 1, 0, 0, 0);

    // Wrap up from 0 over 12 cycles (PRE times more with prescaler).
    drive(0, 1, 1, 0, 0);
`ifdef CNTR_PRESCALE_EN
    repeat (12 * PRE) drive(1, 1, 0, 0, 0);
`else
    repeat (12) drive(1, 1, 0, 0, 0);
`endif

    // Down toward 0 from a load of 2.
    drive(1, 0, 0, 1, 2);
`ifdef CNTR_PRESCALE_EN
    repeat (5 * PRE) drive(1, 0, 0, 0, 0);
`else
    repeat (5) drive(1, 0, 0, 0, 0);
`endif

    // Priority clr > load > en, then clamped load.
    drive(1, 1, 1, 1, 7);
    drive(1, 1, 0, 1, 12);

    // Direction change and enable hold.
    drive(1, 1, 0, 1, 4);
    drive(1, 0, 0, 0, 0);
    repeat (3) drive(0, 0, 0, 0, 0);

    // Prescaler phase across en=0.
    drive(0, 1, 1, 0, 0);
    repeat (6) drive(1, 1, 0, 0, 0);
    repeat (3) drive(0, 1, 0, 0, 0);
    repeat (10) drive(1, 1, 0, 0, 0);

    // Random traffic: clr rare, load occasional, load_val spans the clamp range.
    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      drive(($urandom_range(0, 9) != 0), $urandom_range(0, 1) == 1,
            r < 3, (r >= 3 && r < 10), int'($urandom_range(0, 15)));
    end

    @(negedge clk);
    set_idle();
    for (int i = 0; i < 10 && sbq.size() != 0; i++) @(posedge clk);
    #2;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/param_updown_counter.md
Name: param_updown_counter

Overview:
- Parametrised successor to the 4-bit simple up counter: configurable width and modulus, up/down direction, enable, synchronous clear and load.
- Selectable wrap or saturate mode, plus terminal-count and overflow flags.
- General-purpose event/timebase counter for the Stage 3 designs; drop-in where a plain up counter was used (en=1, up=1, clr=0, load=0).

Parameters:
- WIDTH, 4, counter width in bits (1..32).
- MAX_VAL, 2**WIDTH-1, highest count value; counting range is 0..MAX_VAL. Must be <= 2**WIDTH-1.
- SAT_MODE, 0, 0 = wrap at boundaries, 1 = saturate at boundaries.
- PRESCALE, 4, divide ratio used only when CNTR_PRESCALE_EN is defined (>= 2).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- en  input  1  count enable
- up  input  1  direction: 1 = increment, 0 = decrement
- clr  input  1  synchronous clear to 0
- load  input  1  synchronous load of load_val
- load_val  input  WIDTH  value to load
- count  output  WIDTH  registered count value
- at_term  output  1  combinational: (up & count==MAX_VAL) | (~up & count==0)
- ovf  output  1  registered one-cycle pulse on a boundary event

Behaviour:
- Reset (async, rst=1): count=0, ovf=0, prescaler=0, effective immediately with no clock edge required. Release is sampled at the next rising edge.
- Per-edge priority: clr > load > en. Inputs are sampled at the rising edge and the result is visible one cycle later.
- clr=1: count<=0, ovf<=0.
- load=1 (clr=0):
  - count<=load_val if load_val<=MAX_VAL, otherwise count<=MAX_VAL (clamp).
  - ovf<=0.
- en=1, clr=0, load=0 is an "advance" cycle:
  - up=1, count<MAX_VAL: count+1.
  - up=0, count>0: count-1.
  - up=1, count==MAX_VAL:
    - SAT_MODE=0: count<=0.
    - SAT_MODE=1: count holds.
    - Either mode: ovf<=1.
  - up=0, count==0:
    - SAT_MODE=0: count<=MAX_VAL.
    - SAT_MODE=1: count holds.
    - Either mode: ovf<=1.
- en=0 (no clr/load): count holds, ovf<=0.
- ovf is high for exactly one cycle per boundary event. Back-to-back events (e.g. MAX_VAL=0 with en held) keep ovf high continuously.
- Direction change mid-count takes effect at the next edge; there is no extra latency.
- Arithmetic is unsigned WIDTH bits. No intermediate wider-than-WIDTH state is visible.
- at_term does not depend on en. It is valid in the same cycle as count.

Optional Feature:
- Macro: CNTR_PRESCALE_EN.
- Defined:
  - Adds an internal prescaler of clog2(PRESCALE) bits that increments only on advance cycles (en=1, clr=0, load=0).
  - count advances, and ovf may pulse, only on the advance cycle in which the prescaler equals PRESCALE-1; the prescaler then returns to 0.
  - Prescaler resets on rst, clr or load, and holds when en=0.
  - at_term is unchanged.
- Not defined: no prescaler logic; every advance cycle advances count. PRESCALE is ignored.

Test Plan:
- Reset mid-count, async: WIDTH=4, MAX_VAL=9, count at 5; raise rst between clock edges -> count=0 and ovf=0 before the next rising edge; hold for 2 cycles, release -> counting resumes 0,1,2.
- Wrap up, SAT_MODE=0, MAX_VAL=9: en=1, up=1 from 0 for 12 cycles -> 0..9,0,1; ovf high only in the cycle count shows 0 after 9; at_term=1 while count=9.
- Down saturate, SAT_MODE=1, MAX_VAL=9: load 2, then en=1, up=0 for 5 cycles -> 2,1,0,0,0; ovf pulses on each blocked decrement at 0; at_term=1 while count=0.
- Priority: clr=1, load=1 (load_val=7), en=1 on the same edge -> count=0; next edge load=1, load_val=12, en=1 -> count=9 (clamped), ovf=0.
- Direction/enable: at count=4 toggle up=0 with en=1 -> 3 on the next edge; en=0 for 3 cycles -> count stays 3, ovf=0.
- CNTR_PRESCALE_EN, PRESCALE=4, en=1, up=1 from 0 for 16 cycles -> count increments every 4th cycle, reaching 4; en=0 mid-period, then en=1 -> prescaler phase is preserved (no early step).
